sn74hc595_drv: RTL and testbench



---
 rtl/sn74hc595_pkg.sv | 25 ++
 rtl/sn74hc595_drv_div_tick.sv | 43 ++++
 rtl/sn74hc595_drv.sv | 141 ++++++++++++++
 tb/tb_sn74hc595_drv.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sn74hc595_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sn74hc595_pkg                                              |
// | Description : Shared definitions for the 74HC595 chain writer: the       |
// |               one-hot FSM state encoding and a counter-width helper.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sn74hc595_pkg;

  // One-hot transfer states
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_SH_LO = 5'b00010,
    ST_SH_HI = 5'b00100,
    ST_LATCH = 5'b01000,
    ST_GAP   = 5'b10000
  } state_t;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sn74hc595_drv_div_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_tick                                                   |
// | Description : Modulo-DIV clock-enable divider. Counts MCLK cycles and    |
// |               flags the terminal count (DIV-1) on tick.                  |
// | Ports       : MCLK   - system clock                                      |
// |               nRESET - async active-low reset                            |
// |               clr    - hold/restart the count at 0                       |
// |               tick   - high while count == DIV-1                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module div_tick
  import sn74hc595_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic clr,
  output logic tick
);

  localparam int            CW       = cnt_w(DIV);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // The count wraps on its own terminal count, so consecutive phases of
  // equal length need no explicit clear from the FSM.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/sn74hc595_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sn74hc595_drv                                              |
// | Description : Serial writer for a daisy chain of 74HC595 shift           |
// |               registers. Shifts a WIDTH-bit word out MSB first on        |
// |               SER/SRCLK, then pulses RCLK to latch it. Slow interface    |
// |               timing comes from a clock-enable divider on MCLK.          |
// | Ports       : MCLK, nRESET     - clock, async active-low reset           |
// |               D, START         - word to send, transfer request          |
// |               BUSY, DONE       - transfer in progress, latched pulse     |
// |               SER, SRCLK, RCLK - 595 data, shift clock, storage clock   |
// |               nOE              - 595 output enable (active-low)          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sn74hc595_drv
  import sn74hc595_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV   = 16
) (
  input  logic             MCLK,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             SER,
  output logic             SRCLK,
  output logic             RCLK,
  output logic             nOE
);

  localparam int             BCW      = cnt_w(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_t             state_q;
  // The current MSB lives in ser_q, so the shift register only holds the
  // WIDTH-1 bits still waiting to go out.
  logic [WIDTH-2:0]   shreg_q;
  logic [BCW-1:0]     bitcnt_q;
  logic               busy_q;
  logic               done_q;
  logic               ser_q;
  logic               srclk_q;
  logic               rclk_q;
  logic               noe_q;

  logic               tick;
  logic               div_clr;

  // Divider idles at 0 so the first SH_LO phase starts with a full count;
  // every later state change happens on tick, which restarts the count.
  assign div_clr = (state_q == ST_IDLE);

  div_tick #(
    .DIV (DIV)
  ) u_div (
    .MCLK   (MCLK),
    .nRESET (nRESET),
    .clr    (div_clr),
    .tick   (tick)
  );

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ser_q    <= 1'b0;
      srclk_q  <= 1'b0;
      rclk_q   <= 1'b0;
      noe_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            ser_q    <= D[WIDTH-1];
            shreg_q  <= D[WIDTH-2:0];
            bitcnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SH_LO;
          end
        end
        ST_SH_LO: begin
          if (tick) begin
            srclk_q <= 1'b1;
            state_q <= ST_SH_HI;
          end
        end
        ST_SH_HI: begin
          if (tick) begin
            srclk_q <= 1'b0;
            if (bitcnt_q == LAST_BIT) begin
              // SER keeps the last bit (D[0]) until the next load
              rclk_q  <= 1'b1;
              state_q <= ST_LATCH;
            end else begin
              // SER only moves together with the SRCLK falling edge
              ser_q    <= shreg_q[WIDTH-2];
              shreg_q  <= {shreg_q[WIDTH-3:0], 1'b0};
              bitcnt_q <= bitcnt_q + 1'b1;
              state_q  <= ST_SH_LO;
            end
          end
        end
        ST_LATCH: begin
          if (tick) begin
            rclk_q  <= 1'b0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            noe_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          srclk_q <= 1'b0;
          rclk_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SER   = ser_q;
  assign SRCLK = srclk_q;
  assign RCLK  = rclk_q;
  assign nOE   = noe_q;

endmodule
`default_nettype wire

// File: tb/tb_sn74hc595_drv.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_sn74hc595_drv                                           |
// | Description : Self-checking bench for sn74hc595_drv. Three instances    |
// |               (16/16, 8/1, 32/256) each feed a behavioural 74HC595       |
// |               model; latched words, edge counts and latencies are        |
// |               compared against values computed from the stimulus.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sn74hc595_drv;

  logic MCLK = 1'b0;
  logic nRESET = 1'b0;
  always #12.5 MCLK = ~MCLK;

  // instance 0: WIDTH=16 DIV=16
  logic [15:0] D0 = '0;
  logic START0 = 1'b0;
  logic BUSY0, DONE0, SER0, SRCLK0, RCLK0, nOE0;
  // instance 1: WIDTH=8 DIV=1
  logic [7:0] D1 = '0;
  logic START1 = 1'b0;
  logic BUSY1, DONE1, SER1, SRCLK1, RCLK1, nOE1;
  // instance 2: WIDTH=32 DIV=256
  logic [31:0] D2 = '0;
  logic START2 = 1'b0;
  logic BUSY2, DONE2, SER2, SRCLK2, RCLK2, nOE2;

  sn74hc595_drv #(.WIDTH(16), .DIV(16)) u0 (
    .MCLK(MCLK), .nRESET(nRESET), .D(D0), .START(START0), .BUSY(BUSY0),
    .DONE(DONE0), .SER(SER0), .SRCLK(SRCLK0), .RCLK(RCLK0), .nOE(nOE0));
  sn74hc595_drv #(.WIDTH(8), .DIV(1)) u1 (
    .MCLK(MCLK), .nRESET(nRESET), .D(D1), .START(START1), .BUSY(BUSY1),
    .DONE(DONE1), .SER(SER1), .SRCLK(SRCLK1), .RCLK(RCLK1), .nOE(nOE1));
  sn74hc595_drv #(.WIDTH(32), .DIV(256)) u2 (
    .MCLK(MCLK), .nRESET(nRESET), .D(D2), .START(START2), .BUSY(BUSY2),
    .DONE(DONE2), .SER(SER2), .SRCLK(SRCLK2), .RCLK(RCLK2), .nOE(nOE2));

  // ---------------- behavioural 74HC595 chains ----------------
  logic [31:0] sh0 = '0, st0 = '0, sh1 = '0, st1 = '0, sh2 = '0, st2 = '0;
  int sr0 = 0, rr0 = 0, sr1 = 0, rr1 = 0, sr2 = 0, rr2 = 0;
  always @(posedge SRCLK0) begin sh0 = {sh0[30:0], SER0}; sr0++; end
  always @(posedge RCLK0)  begin st0 = sh0; rr0++; end
  always @(posedge SRCLK1) begin sh1 = {sh1[30:0], SER1}; sr1++; end
  always @(posedge RCLK1)  begin st1 = sh1; rr1++; end
  always @(posedge SRCLK2) begin sh2 = {sh2[30:0], SER2}; sr2++; end
  always @(posedge RCLK2)  begin st2 = sh2; rr2++; end

  // SER setup/hold monitor on instance 0: SER must not change in the 16
  // samples before a SRCLK rise nor in the 15 samples after it.
  int   ser_age = 1000;
  int   hold_win = 0;
  int   stab_viol = 0;
  logic ser_prev = 1'b0, sck_prev = 1'b0;
  always @(negedge MCLK) begin
    if (SER0 !== ser_prev) begin
      if (hold_win > 0) stab_viol++;
      ser_age = 0;
    end else begin
      ser_age++;
    end
    if (hold_win > 0) hold_win--;
    if (SRCLK0 && !sck_prev) begin
      if (ser_age < 16) stab_viol++;
      hold_win = 15;
    end
    ser_prev = SER0;
    sck_prev = SRCLK0;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_done(input int sel);
    case (sel)
      0:       return DONE0;
      1:       return DONE1;
      default: return DONE2;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v, input logic [31:0] d);
    case (sel)
      0: begin START0 = v; D0 = d[15:0]; end
      1: begin START1 = v; D1 = d[7:0]; end
      default: begin START2 = v; D2 = d; end
    endcase
  endtask

  // Wait for DONE, counting edges after the accepting edge; returns -1 on timeout.
  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (!f_done(sel) && lat < 40000) begin
      @(posedge MCLK); #1;
      lat++;
    end
    if (!f_done(sel)) lat = -1;
  endtask

  // One complete transfer: START for exactly the accepting edge.
  task automatic xfer(input int sel, input logic [31:0] d, output int lat);
    @(negedge MCLK);
    set_start(sel, 1'b1, d);
    @(posedge MCLK); #1;
    set_start(sel, 1'b0, d);
    wait_done(sel, lat);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, lat2, s0, r0, v0, idle_bad;
    logic [15:0] w;

    // Reset values
    repeat (4) @(negedge MCLK);
    chk("rst_SER", SER0, 1'b0);
    chk("rst_SRCLK", SRCLK0, 1'b0);
    chk("rst_RCLK", RCLK0, 1'b0);
    chk("rst_BUSY", BUSY0, 1'b0);
    chk("rst_DONE", DONE0, 1'b0);
    chk("rst_nOE", nOE0, 1'b1);

    // Idle for 1000 cycles after release with START low
    nRESET = 1'b1;
    idle_bad = 0;
    repeat (1000) begin
      @(negedge MCLK);
      if ({SER0, SRCLK0, RCLK0, BUSY0, DONE0, nOE0} !== 6'b000001) idle_bad++;
    end
    chk("idle_quiet", idle_bad, 0);

    // Single word A5C3
    s0 = sr0; r0 = rr0;
    xfer(0, 32'h0000_A5C3, lat);
    chk("single_lat", lat, (2 * 16 + 2) * 16);
    chk("single_data", st0[15:0], 16'hA5C3);
    chk("single_srclk_rises", sr0 - s0, 16);
    chk("single_rclk_rises", rr0 - r0, 1);
    chk("single_nOE_low", nOE0, 1'b0);
    chk("single_busy_clr", BUSY0, 1'b0);
    chk("single_ser_d0", SER0, 1'b1);
    chk("ser_setup_hold", stab_viol, 0);
    @(posedge MCLK); #1;
    chk("done_one_cycle", DONE0, 1'b0);

    // Random words
    repeat (3) begin
      w = 16'($urandom);
      s0 = sr0;
      xfer(0, {16'h0, w}, lat);
      chk("rand_data", st0[15:0], w);
      chk("rand_lat", lat, 544);
      chk("rand_rises", sr0 - s0, 16);
    end

    // Back-to-back with START held high
    s0 = sr0; r0 = rr0;
    @(negedge MCLK);
    START0 = 1'b1; D0 = 16'h0001;
    @(posedge MCLK); #1;
    D0 = 16'hFFFF;
    wait_done(0, lat);
    chk("b2b_lat1", lat, 544);
    chk("b2b_data1", st0[15:0], 16'h0001);
    @(posedge MCLK); #1;
    chk("b2b_busy_next", BUSY0, 1'b1);
    START0 = 1'b0;
    wait_done(0, lat2);
    chk("b2b_lat2", lat2, 544);
    chk("b2b_data2", st0[15:0], 16'hFFFF);
    chk("b2b_srclk_rises", sr0 - s0, 32);
    chk("b2b_rclk_rises", rr0 - r0, 2);

    // START pulsed while BUSY: ignored, not queued
    s0 = sr0; r0 = rr0;
    w = 16'($urandom);
    @(negedge MCLK);
    START0 = 1'b1; D0 = w;
    @(posedge MCLK); #1;
    START0 = 1'b0;
    repeat (5) begin
      repeat (40 + $urandom_range(0, 20)) @(negedge MCLK);
      D0 = ~D0; START0 = 1'b1;
      @(negedge MCLK);
      START0 = 1'b0;
    end
    wait_done(0, lat);
    chk("ign_data", st0[15:0], w);
    repeat (600) @(negedge MCLK);
    chk("ign_busy", BUSY0, 1'b0);
    chk("ign_srclk_rises", sr0 - s0, 16);
    chk("ign_rclk_rises", rr0 - r0, 1);

    // Reset after 7 SRCLK rises
    s0 = sr0; r0 = rr0; w = st0[15:0];
    @(negedge MCLK);
    START0 = 1'b1; D0 = 16'hBEEF;
    @(posedge MCLK); #1;
    START0 = 1'b0;
    v0 = 0;
    while ((sr0 - s0) < 7 && v0 < 5000) begin @(negedge MCLK); v0++; end
    chk("mid_seven_rises", sr0 - s0, 7);
    nRESET = 1'b0;
    #1;
    chk("mid_rst_outs", {SER0, SRCLK0, RCLK0, BUSY0, DONE0, nOE0}, 6'b000001);
    repeat (3) @(negedge MCLK);
    chk("mid_no_rclk", rr0 - r0, 0);
    chk("mid_storage_kept", st0[15:0], w);
    nRESET = 1'b1;
    repeat (5) @(negedge MCLK);
    chk("mid_idle_after", {BUSY0, nOE0}, 2'b01);
    xfer(0, 32'h0000_1234, lat);
    chk("post_rst_data", st0[15:0], 16'h1234);
    chk("post_rst_lat", lat, 544);

    // DIV=1, WIDTH=8
    s0 = sr1; r0 = rr1;
    xfer(1, 32'h0000_005A, lat);
    chk("div1_lat", lat, (2 * 8 + 2) * 1);
    chk("div1_data", st1[7:0], 8'h5A);
    chk("div1_rises", sr1 - s0, 8);
    chk("div1_rclk", rr1 - r0, 1);
    w = 16'($urandom);
    xfer(1, {24'h0, w[7:0]}, lat);
    chk("div1_rand_data", st1[7:0], w[7:0]);

    // DIV=256, WIDTH=32
    s0 = sr2; r0 = rr2;
    xfer(2, 32'hC0DE_F00D, lat);
    chk("div256_lat", lat, (2 * 32 + 2) * 256);
    chk("div256_data", st2, 32'hC0DE_F00D);
    chk("div256_rises", sr2 - s0, 32);
    chk("div256_rclk", rr2 - r0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
